// File: rtl/regfile_mp_sb_pkg.sv
// Shared helpers for the multi-port register file.
// Address width derivation and flat-bus slice offsets.
package regfile_mp_sb_pkg;

  localparam logic DATA_ZERO_BIT = 1'b0;

  function automatic int aw_of(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int slice_lo(
    input int idx,
    input int w
  );
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: set at issue, cleared at writeback.
// Set beats clear on the same register; r0 optionally never busy.
module regfile_scoreboard
  import regfile_mp_sb_pkg::*;
#(
  parameter int REGI_DEPTH = 32,
  parameter int NUM_WR = 1,
  parameter int ZERO_REG = 1,
  localparam int AW = aw_of(REGI_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_rd,
  input  logic [NUM_WR-1:0]      wen,
  input  logic [NUM_WR*AW-1:0]   waddr,
  output logic [REGI_DEPTH-1:0]  busy
);

  logic [REGI_DEPTH-1:0] busy_q;
  logic [REGI_DEPTH-1:0] busy_d;

  // Next state: clears from writeback first, then issue set on top
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wen[j]) begin
        busy_d[waddr[slice_lo(j, AW) +: AW]] = 1'b0;
      end
    end
    if (iss_valid) begin
      busy_d[iss_rd] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  // Busy bit register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = rst ? '0 : busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with bypass and scoreboard.
// Higher write port wins on address conflicts.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int REGI_DEPTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 1,
  localparam int AW = aw_of(REGI_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*AW-1:0]         raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic [NUM_WR-1:0]            wen,
  input  logic [NUM_WR*AW-1:0]         waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
  input  logic                         iss_valid,
  input  logic [AW-1:0]                iss_rd,
  output logic [REGI_DEPTH-1:0]        busy_vec
);

  localparam logic [DATA_WIDTH-1:0] ZERO_D =
    {DATA_WIDTH{DATA_ZERO_BIT}};

  logic [DATA_WIDTH-1:0] rf [REGI_DEPTH];

  logic [AW-1:0]         ra;
  logic                  hit;
  logic [DATA_WIDTH-1:0] byp_d;
  logic [DATA_WIDTH-1:0] rd_d;

  regfile_scoreboard #(
    .REGI_DEPTH (REGI_DEPTH),
    .NUM_WR     (NUM_WR),
    .ZERO_REG   (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .wen       (wen),
    .waddr     (waddr),
    .busy      (busy_vec)
  );

  // Storage: reset clears, later ports overwrite earlier ones
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REGI_DEPTH; r++) begin
        rf[r] <= ZERO_D;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wen[j] &&
            !(ZERO_REG != 0 &&
              waddr[slice_lo(j, AW) +: AW] == '0)) begin
          rf[waddr[slice_lo(j, AW) +: AW]] <=
            wdata[slice_lo(j, DATA_WIDTH) +: DATA_WIDTH];
        end
      end
    end
  end

  // Read ports with optional same-cycle write bypass
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    hit   = 1'b0;
    byp_d = ZERO_D;
    rd_d  = ZERO_D;
    for (int i = 0; i < NUM_RD; i++) begin
      ra    = raddr[slice_lo(i, AW) +: AW];
      hit   = 1'b0;
      byp_d = ZERO_D;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wen[j] &&
            waddr[slice_lo(j, AW) +: AW] == ra) begin
          hit   = 1'b1;
          byp_d =
            wdata[slice_lo(j, DATA_WIDTH) +: DATA_WIDTH];
        end
      end
      if (BYPASS != 0 && hit) begin
        rd_d = byp_d;
      end else begin
        rd_d = rf[ra];
      end
      if (ZERO_REG != 0 && ra == '0) begin
        rd_d = ZERO_D;
      end
      if (!rst) begin
        rdata[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] = rd_d;
        rbusy[i] = busy_vec[ra] &&
                   !(BYPASS != 0 && hit);
      end
    end
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the pipelined NPC core.
- Generalises the single-write, dual-read file to NUM_RD read ports and NUM_WR write ports.
- Adds optional write-to-read bypass, deterministic write-port priority, and a per-register busy scoreboard (set at issue, cleared at writeback).
- Sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
REGI_DEPTH, 32, number of architectural registers (power of two, >=2); AW = $clog2(REGI_DEPTH)
DATA_WIDTH, 64, register width in bits
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 1, number of write ports (1..2)
BYPASS, 1, 1 = read ports see same-cycle write data; 0 = reads return stored value only
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
raddr  in  NUM_RD*AW  read addresses, port i at [i*AW +: AW]
rdata  out  NUM_RD*DATA_WIDTH  read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
rbusy  out  NUM_RD  busy flag of register addressed by read port i
wen  in  NUM_WR  write enable per write port
waddr  in  NUM_WR*AW  write addresses
wdata  in  NUM_WR*DATA_WIDTH  write data
iss_valid  in  1  issue of an instruction that will write iss_rd
iss_rd  in  AW  destination register being issued
busy_vec  out  REGI_DEPTH  full scoreboard state, bit r = register r busy

Behaviour:
- Reset:
  - rst high at a rising edge clears all registers to 0 and all busy bits to 0.
  - While rst is high, rdata = 0, rbusy = 0 and busy_vec = 0 combinationally; writes and issues are ignored.
- Write:
  - For each port j with wen[j]=1, rf[waddr[j]] <= wdata[j] at the edge.
  - Same waddr on several enabled ports: highest-index port wins.
  - ZERO_REG=1 and waddr=0: write discarded.
- Read (combinational, 0-cycle latency):
  - ZERO_REG=1 and raddr=0: rdata = 0.
  - Else if BYPASS=1 and any enabled write port targets raddr this cycle: rdata = that port's wdata (highest index wins).
  - Else rdata = rf[raddr].
- Scoreboard:
  - iss_valid=1 sets busy[iss_rd] at the edge.
  - Any wen[j]=1 clears busy[waddr[j]] at the edge.
  - Set and clear on the same register in the same cycle: set wins (new producer outstanding).
  - ZERO_REG=1: busy[0] is constant 0; issue to r0 ignored.
- rbusy[i]:
  - BYPASS=1: busy[raddr[i]] AND NOT (some enabled write targets raddr[i] this cycle).
  - BYPASS=0: busy[raddr[i]] as registered.
- busy_vec reflects registered state only, without bypass masking.
- Write to a non-busy register is legal: data is written and the busy bit stays 0.
- Reset asserted mid-operation overrides all same-cycle writes and issues.
- No X propagation: every output is defined from reset onward.

Decomposition:
- Shared package: AW derivation helper, data-zero constant, port-slice index functions for the flattened buses.
- Sub-module regfile_scoreboard: busy bit vector with set/clear priority, reset and ZERO_REG masking.
- Storage array, write arbitration and read/bypass muxes stay in the top module.

Test Plan:
1. Reset: write r5=0x1234, pulse rst for one cycle -> next cycle read r5 = 0, busy_vec = 0; rdata = 0 while rst high.
2. Zero register: wen=1, waddr=0, wdata=0xFFFF_FFFF_FFFF_FFFF, iss_valid with iss_rd=0 -> read r0 = 0, busy_vec[0] = 0.
3. Bypass: BYPASS=1, same cycle write r7=0xDEAD and read r7 on ports 0 and 1 -> both ports 0xDEAD with rbusy=0; BYPASS=0 -> old value 0 that cycle, 0xDEAD next cycle.
4. Write conflict: NUM_WR=2, both ports write r3 (port0 0x11, port1 0x22) -> r3 = 0x22 next cycle; bypassed read shows 0x22.
5. Scoreboard:
   - Issue r9 -> busy_vec[9]=1 next cycle, rbusy=1 on reads of r9.
   - Write r9=0x55 -> rbusy=0 in the same cycle (BYPASS=1), busy_vec[9]=0 next cycle.
   - Issue and write r9 in the same cycle -> busy_vec[9] stays 1.
6. Reset mid-flight: busy r4 and r12, assert rst together with wen to r4=0x99 -> afterwards r4 = 0 and busy_vec = 0.
